dca_tensor_scalar_divider: RTL and testbench



---
 rtl/dca_tensor_scalar_divider_pkg.sv | 13 +
 rtl/dca_divider_step.sv | 24 ++
 rtl/dca_tensor_scalar_divider.sv | 117 +++++++++++
 tb/tb_dca_tensor_scalar_divider.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dca_tensor_scalar_divider_pkg.sv
// Shared constants for the DCA tensor-scalar divider: default data width and FSM encodings.
package dca_tensor_scalar_divider_pkg;

  localparam int TENSOR_BW_INTEGER = 32;
  localparam int DIV_BW_DATA       = TENSOR_BW_INTEGER;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/dca_divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract the divisor if it fits.
module dca_divider_step #(
  parameter int BW_DATA = 32
) (
  input  logic [BW_DATA:0]   rem_in,
  input  logic               next_bit,
  input  logic [BW_DATA-1:0] divisor,
  output logic [BW_DATA:0]   rem_out,
  output logic               quotient_bit
);

  logic [BW_DATA+1:0] shifted;
  logic [BW_DATA+1:0] divisor_ext;

  always_comb begin
    shifted      = {rem_in, next_bit};
    divisor_ext  = {2'b00, divisor};
    quotient_bit = (shifted >= divisor_ext);
    // The running remainder never reaches 2*divisor, so the top bit drops out after subtraction
    rem_out      = quotient_bit ? (BW_DATA+1)'(shifted - divisor_ext)
                                : (BW_DATA+1)'(shifted);
  end

endmodule

// File: rtl/dca_tensor_scalar_divider.sv
// Handshaked signed/unsigned restoring divider, one quotient bit per enabled cycle.
module dca_tensor_scalar_divider
  import dca_tensor_scalar_divider_pkg::*;
#(
  parameter int BW_DATA = DIV_BW_DATA
) (
  input  logic               clk,
  input  logic               rstnn,
  input  logic               enable,
  input  logic               input_wvalid,
  output logic               input_wready,
  input  logic               input_is_signed,
  input  logic [BW_DATA-1:0] input_dividend,
  input  logic [BW_DATA-1:0] input_divisor,
  output logic               output_rvalid,
  input  logic               output_rready,
  output logic [BW_DATA-1:0] output_quotient,
  output logic [BW_DATA-1:0] output_remainder,
  output logic               output_div_by_zero
);

  localparam int BW_COUNT = $clog2(BW_DATA) + 1;
  localparam logic [BW_COUNT-1:0] COUNT_INIT = BW_COUNT'(BW_DATA);

  div_state_e         state, state_next;
  logic [BW_COUNT-1:0] count;
  logic [BW_DATA:0]   rem_reg, step_rem;
  logic [BW_DATA-1:0] shift_reg, divisor_mag;
  logic               sign_a, sign_b, step_qbit;
  logic               accept, dividend_neg, divisor_neg;
  logic [BW_DATA-1:0] dividend_abs, divisor_abs;
  logic [BW_DATA-1:0] quot_next, quot_fixed, rem_fixed;

  assign input_wready  = enable & (state == DIV_IDLE);
  assign accept        = input_wvalid & input_wready;
  assign output_rvalid = (state == DIV_DONE);

  // shift_reg starts as |dividend| and fills from the right with quotient bits
  dca_divider_step #(.BW_DATA(BW_DATA)) u_step (
    .rem_in       (rem_reg),
    .next_bit     (shift_reg[BW_DATA-1]),
    .divisor      (divisor_mag),
    .rem_out      (step_rem),
    .quotient_bit (step_qbit)
  );

  always_comb begin
    dividend_neg = input_is_signed & input_dividend[BW_DATA-1];
    divisor_neg  = input_is_signed & input_divisor[BW_DATA-1];
    dividend_abs = dividend_neg ? -input_dividend : input_dividend;
    divisor_abs  = divisor_neg  ? -input_divisor  : input_divisor;
    quot_next    = {shift_reg[BW_DATA-2:0], step_qbit};
    // Truncating division: remainder follows the dividend's sign
    quot_fixed   = (sign_a ^ sign_b) ? -quot_next : quot_next;
    rem_fixed    = sign_a ? -step_rem[BW_DATA-1:0] : step_rem[BW_DATA-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE: if (accept) state_next = (input_divisor == '0) ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (count == BW_COUNT'(1)) state_next = DIV_DONE;
      DIV_DONE: if (output_rready) state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) state <= DIV_IDLE;
    else if (enable) state <= state_next;
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      count              <= '0;
      rem_reg            <= '0;
      shift_reg          <= '0;
      divisor_mag        <= '0;
      sign_a             <= 1'b0;
      sign_b             <= 1'b0;
      output_quotient    <= '0;
      output_remainder   <= '0;
      output_div_by_zero <= 1'b0;
    end else if (enable) begin
      case (state)
        DIV_IDLE: begin
          if (accept) begin
            sign_a      <= dividend_neg;
            sign_b      <= divisor_neg;
            shift_reg   <= dividend_abs;
            divisor_mag <= divisor_abs;
            rem_reg     <= '0;
            count       <= COUNT_INIT;
            // A zero divisor skips iteration and reports the raw dividend straight away
            if (input_divisor == '0) begin
              output_quotient    <= '1;
              output_remainder   <= input_dividend;
              output_div_by_zero <= 1'b1;
            end
          end
        end
        DIV_CALC: begin
          rem_reg   <= step_rem;
          shift_reg <= quot_next;
          count     <= count - BW_COUNT'(1);
          if (count == BW_COUNT'(1)) begin
            output_quotient    <= quot_fixed;
            output_remainder   <= rem_fixed;
            output_div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dca_tensor_scalar_divider.sv
// Table-driven and randomized checks of the tensor-scalar divider against an arithmetic model.
module tb_dca_tensor_scalar_divider;

  localparam int BW = 32;

  typedef struct {
    logic          s;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic [BW-1:0] q;
    logic [BW-1:0] r;
    logic          dz;
    int            lat;
    int            stall_at;
    int            hold;
  } vec_t;

  logic          clk = 1'b0;
  logic          rstnn = 1'b0;
  logic          enable = 1'b1;
  logic          input_wvalid = 1'b0;
  logic          input_is_signed = 1'b0;
  logic          output_rready = 1'b0;
  logic [BW-1:0] input_dividend = '0;
  logic [BW-1:0] input_divisor = '0;
  logic          input_wready, output_rvalid, output_div_by_zero;
  logic [BW-1:0] output_quotient, output_remainder;

  int checks = 0;
  int failures = 0;

  dca_tensor_scalar_divider #(.BW_DATA(BW)) dut (
    .clk                (clk),
    .rstnn              (rstnn),
    .enable             (enable),
    .input_wvalid       (input_wvalid),
    .input_wready       (input_wready),
    .input_is_signed    (input_is_signed),
    .input_dividend     (input_dividend),
    .input_divisor      (input_divisor),
    .output_rvalid      (output_rvalid),
    .output_rready      (output_rready),
    .output_quotient    (output_quotient),
    .output_remainder   (output_remainder),
    .output_div_by_zero (output_div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Plain-arithmetic reference: truncating division, zero divisor yields all ones / raw dividend
  function automatic void model(input logic s, input logic [BW-1:0] a, input logic [BW-1:0] b,
                                output logic [BW-1:0] q, output logic [BW-1:0] r, output logic dz);
    longint sa, sb;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    if (b == '0) begin
      q = '1; r = a; dz = 1'b1;
    end else begin
      q = BW'(sa / sb); r = BW'(sa % sb); dz = 1'b0;
    end
  endfunction

  task automatic applyStimulus(input logic s, input logic [BW-1:0] a, input logic [BW-1:0] b,
                               input int stall_at, output int lat);
    @(negedge clk);
    input_is_signed = s;
    input_dividend  = a;
    input_divisor   = b;
    input_wvalid    = 1'b1;
    checkOutput("wready_before_accept", 64'(input_wready), 64'd1);
    @(posedge clk); #1;
    input_wvalid   = 1'b0;
    input_dividend = $urandom();
    input_divisor  = $urandom();
    lat = 1;
    while (!output_rvalid && lat < 200) begin
      if (stall_at > 0 && lat == stall_at) enable = 1'b0;
      if (stall_at > 0 && lat == stall_at + 3) enable = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    enable = 1'b1;
  endtask

  task automatic runVector(input string tag, input vec_t v);
    int lat;
    applyStimulus(v.s, v.a, v.b, v.stall_at, lat);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(v.lat));
    checkOutput({tag, "_quotient"}, 64'(output_quotient), 64'(v.q));
    checkOutput({tag, "_remainder"}, 64'(output_remainder), 64'(v.r));
    checkOutput({tag, "_div_by_zero"}, 64'(output_div_by_zero), 64'(v.dz));
    for (int h = 0; h < v.hold; h++) begin
      input_wvalid = 1'b1;
      @(posedge clk); #1;
      checkOutput({tag, "_hold_rvalid"}, 64'(output_rvalid), 64'd1);
      checkOutput({tag, "_hold_quotient"}, 64'(output_quotient), 64'(v.q));
      checkOutput({tag, "_hold_remainder"}, 64'(output_remainder), 64'(v.r));
      checkOutput({tag, "_hold_wready"}, 64'(input_wready), 64'd0);
    end
    input_wvalid  = 1'b0;
    output_rready = 1'b1;
    @(posedge clk); #1;
    output_rready = 1'b0;
    checkOutput({tag, "_rvalid_after_handoff"}, 64'(output_rvalid), 64'd0);
    checkOutput({tag, "_wready_after_handoff"}, 64'(input_wready), 64'd1);
  endtask

  vec_t vecs[13];

  initial begin
    vec_t v;
    logic [BW-1:0] mq, mr;
    logic mdz;

    vecs[0]  = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33, 0, 5};
    vecs[1]  = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 33, 0, 0};
    vecs[2]  = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0, 33, 0, 0};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33, 0, 0};
    vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1,          1'b0, 33, 0, 0};
    vecs[5]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1,  0, 0};
    vecs[6]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1,  0, 3};
    vecs[7]  = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 36, 10, 0};
    vecs[8]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 33, 0, 0};
    vecs[9]  = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33, 0, 0};
    vecs[10] = '{1'b1, 32'd7,          32'd100,        32'd0,          32'd7,          1'b0, 33, 0, 0};
    vecs[11] = '{1'b0, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0, 33, 0, 0};
    vecs[12] = '{1'b0, 32'hFFFF_FF9C,  32'd7,          32'd613566742,  32'd2,          1'b0, 33, 0, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rvalid", 64'(output_rvalid), 64'd0);
    checkOutput("reset_quotient", 64'(output_quotient), 64'd0);
    checkOutput("reset_remainder", 64'(output_remainder), 64'd0);
    checkOutput("reset_div_by_zero", 64'(output_div_by_zero), 64'd0);
    @(negedge clk);
    rstnn = 1'b1;
    #1;
    checkOutput("reset_wready", 64'(input_wready), 64'd1);

    for (int i = 0; i < 13; i++) begin
      runVector($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset mid-calculation discards the in-flight result
    @(negedge clk);
    input_is_signed = 1'b1;
    input_dividend  = 32'd100;
    input_divisor   = 32'd7;
    input_wvalid    = 1'b1;
    @(posedge clk); #1;
    input_wvalid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rstnn = 1'b0;
    #1;
    checkOutput("midreset_rvalid", 64'(output_rvalid), 64'd0);
    checkOutput("midreset_quotient", 64'(output_quotient), 64'd0);
    checkOutput("midreset_remainder", 64'(output_remainder), 64'd0);
    checkOutput("midreset_div_by_zero", 64'(output_div_by_zero), 64'd0);
    @(negedge clk);
    rstnn = 1'b1;
    #1;
    checkOutput("midreset_wready", 64'(input_wready), 64'd1);
    v = '{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, 0, 0};
    runVector("after_reset", v);

    // Randomized operands against the arithmetic model
    for (int i = 0; i < 60; i++) begin
      int sel;
      v.s = 1'($urandom_range(0, 1));
      v.a = (i % 10 == 3) ? 32'h8000_0000 : $urandom();
      sel = $urandom_range(0, 3);
      if (sel == 0)      v.b = '0;
      else if (sel == 1) v.b = 32'($urandom_range(1, 15));
      else               v.b = $urandom();
      if (sel == 1 && v.s && $urandom_range(0, 1) == 1) v.b = -v.b;
      model(v.s, v.a, v.b, mq, mr, mdz);
      v.q = mq; v.r = mr; v.dz = mdz;
      v.lat = (v.b == '0) ? 1 : 33;
      v.stall_at = 0;
      v.hold = 0;
      runVector("rand", v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
